// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan reader.
//   - Glyph0..GlyphF : segment patterns (bit 6 = a ... bit 0 = g, active-high)
//   - scan_state_e   : stability FSM states
//   - onehot_to_idx  : index of the set bit of an up-to-8-bit one-hot vector
package seg7_pkg;

  localparam logic [6:0] Glyph0 = 7'b1111110;
  localparam logic [6:0] Glyph1 = 7'b0110000;
  localparam logic [6:0] Glyph2 = 7'b1101101;
  localparam logic [6:0] Glyph3 = 7'b1111001;
  localparam logic [6:0] Glyph4 = 7'b0110011;
  localparam logic [6:0] Glyph5 = 7'b1011011;
  localparam logic [6:0] Glyph6 = 7'b1011111;
  localparam logic [6:0] Glyph7 = 7'b1110000;
  localparam logic [6:0] Glyph8 = 7'b1111111;
  localparam logic [6:0] Glyph9 = 7'b1111011;
  localparam logic [6:0] GlyphA = 7'b1110111;
  localparam logic [6:0] GlyphB = 7'b0011111;
  localparam logic [6:0] GlyphC = 7'b1001110;
  localparam logic [6:0] GlyphD = 7'b0111101;
  localparam logic [6:0] GlyphE = 7'b1001111;
  localparam logic [6:0] GlyphF = 7'b1000111;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StLocked
  } scan_state_e;

  // Only meaningful for one-hot input; the highest set bit wins otherwise.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: combinational decode of a 7-segment pattern to a hex nibble.
// Ports:
//   pattern_i [6:0] : segment levels, bit 6 = a ... bit 0 = g, active-high
//   nibble_o  [3:0] : decoded value, 0 when the pattern is not a glyph
//   legal_o         : pattern matches one of the 16 hex glyphs
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b1;
    case (pattern_i)
      Glyph0:  nibble_o = 4'h0;
      Glyph1:  nibble_o = 4'h1;
      Glyph2:  nibble_o = 4'h2;
      Glyph3:  nibble_o = 4'h3;
      Glyph4:  nibble_o = 4'h4;
      Glyph5:  nibble_o = 4'h5;
      Glyph6:  nibble_o = 4'h6;
      Glyph7:  nibble_o = 4'h7;
      Glyph8:  nibble_o = 4'h8;
      Glyph9:  nibble_o = 4'h9;
      GlyphA:  nibble_o = 4'hA;
      GlyphB:  nibble_o = 4'hB;
      GlyphC:  nibble_o = 4'hC;
      GlyphD:  nibble_o = 4'hD;
      GlyphE:  nibble_o = 4'hE;
      GlyphF:  nibble_o = 4'hF;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 7-segment display bus and recovers
// the hex nibble shown on each digit once the bus has held stable.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   seg [6:0]   : segment levels (bit 6 = a), asynchronous
//   an  [D-1:0] : one-hot digit selects, asynchronous
//   clr_err     : clears err_sticky
//   digits      : captured nibbles, digit i in [4i+3:4i]
//   digit_vld   : digit i has captured a legal glyph
//   upd_valid   : one-cycle pulse per capture, qualified by upd_idx/upd_nibble/upd_err
//   err_sticky  : set by any illegal capture, held until clr_err
// Build option: define SEG_ACTIVE_LOW_EN for active-low (common-anode) seg/an.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [6:0]                               seg,
  input  logic [DIGITS-1:0]                        an,
  input  logic                                     clr_err,
  output logic [4*DIGITS-1:0]                      digits,
  output logic [DIGITS-1:0]                        digit_vld,
  output logic                                     upd_valid,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] upd_idx,
  output logic [3:0]                               upd_nibble,
  output logic                                     upd_err,
  output logic                                     err_sticky
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned BusW = DIGITS + 7;

  logic [BusW-1:0] sync1_q, sync2_q, prev_q;
  logic [BusW-1:0] s;
  logic [DIGITS-1:0] s_an;
  logic [6:0]        s_seg;
  logic              change, sel_ok;

  scan_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              capture;

  logic [3:0]        dec_nibble;
  logic              dec_legal;
  logic [IdxW-1:0]   cap_idx;

  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   digit_vld_q, digit_vld_d;
  logic                upd_valid_q, upd_valid_d;
  logic [IdxW-1:0]     upd_idx_q, upd_idx_d;
  logic [3:0]          upd_nibble_q, upd_nibble_d;
  logic                upd_err_q, upd_err_d;
  logic                err_sticky_q, err_sticky_d;

`ifdef SEG_ACTIVE_LOW_EN
  assign s = ~sync2_q;
`else
  assign s = sync2_q;
`endif

  assign s_an   = s[BusW-1:7];
  assign s_seg  = s[6:0];
  assign change = (s != prev_q);
  assign sel_ok = $onehot(s_an);

  seg7_to_hex u_seg7_to_hex (
    .pattern_i (s_seg),
    .nibble_o  (dec_nibble),
    .legal_o   (dec_legal)
  );

  assign cap_idx = IdxW'(onehot_to_idx(8'(s_an)));

  // Stability FSM: a change always restarts the count (or drops to idle on a
  // bad select); LOCKED suppresses re-capture of a held value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (change && sel_ok) begin
          state_d = StCount;
          cnt_d   = CntW'(1);
        end
      end
      StCount: begin
        if (change) begin
          state_d = sel_ok ? StCount : StIdle;
          cnt_d   = sel_ok ? CntW'(1) : '0;
        end else if (cnt_q >= CntW'(STABLE_CYCLES)) begin
          capture = 1'b1;
          state_d = StLocked;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLocked: begin
        if (change) begin
          state_d = sel_ok ? StCount : StIdle;
          cnt_d   = sel_ok ? CntW'(1) : '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    digits_d     = digits_q;
    digit_vld_d  = digit_vld_q;
    upd_valid_d  = capture;
    upd_idx_d    = '0;
    upd_nibble_d = 4'h0;
    upd_err_d    = 1'b0;
    err_sticky_d = err_sticky_q & ~clr_err;
    if (capture) begin
      upd_idx_d = cap_idx;
      if (dec_legal) begin
        upd_nibble_d               = dec_nibble;
        digits_d[cap_idx*4 +: 4]   = dec_nibble;
        digit_vld_d[cap_idx]       = 1'b1;
      end else begin
        upd_err_d    = 1'b1;
        // A new error wins over a simultaneous clear.
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      digits_q     <= '0;
      digit_vld_q  <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_nibble_q <= 4'h0;
      upd_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      sync1_q      <= {an, seg};
      sync2_q      <= sync1_q;
      prev_q       <= s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      digit_vld_q  <= digit_vld_d;
      upd_valid_q  <= upd_valid_d;
      upd_idx_q    <= upd_idx_d;
      upd_nibble_q <= upd_nibble_d;
      upd_err_q    <= upd_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign digits     = digits_q;
  assign digit_vld  = digit_vld_q;
  assign upd_valid  = upd_valid_q;
  assign upd_idx    = upd_idx_q;
  assign upd_nibble = upd_nibble_q;
  assign upd_err    = upd_err_q;
  assign err_sticky = err_sticky_q;

endmodule
